pool_quant_pack: RTL and testbench
==================================

Name: pool_quant_pack

Overview:
- Sits directly downstream of the partial-sum buffer. It consumes the ReLU'd, final convolution outputs, which arrive one pixel per valid cycle in row-major raster order.
- Performs 2x2 stride-2 max pooling, then requantizes each pooled value to an unsigned 8-bit activation.
- Packs four activations into a 32-bit word and presents the words to the output writer through a small FIFO with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 25, width of the incoming ReLU'd partial sum.
- MAX_W, 64, maximum feature-map row width in pixels; sets the line-buffer depth to MAX_W/2.
- W_BITS, 7, width of the cfg_width field and of the column counter.
- OUT_DEPTH, 4, number of 32-bit entries in the output FIFO (power of 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a new frame.
- cfg_width  in  W_BITS  row width in pixels; sampled on start; must be even, 2..MAX_W.
- cfg_shift  in  5  requantization right-shift; sampled on start.
- in_valid  in  1  in_data is a valid pixel this cycle.
- in_data  in  DATA_WIDTH  ReLU'd pixel, treated as unsigned.
- flush  in  1  one-cycle pulse at frame end; emits any partial word.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_data  out  32  packed word; byte 0 in [7:0] is the oldest activation.
- ovf  out  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, ovf=0. Column counter, row parity, pair register, pack register, byte count and FIFO pointers are all cleared.
- Reset mid-frame discards all buffered data. Line-buffer contents need no reset.
- start:
  - Latches cfg_width and cfg_shift.
  - Clears the column counter, row parity, pair register, pack register, byte count, FIFO and ovf.
  - in_valid in the same cycle as start is ignored.
- No backpressure to upstream. in_valid is always accepted.
- Horizontal pairing:
  - Pixel at an even column is held in the pair register.
  - At an odd column, hmax = max(pair register, in_data).
  - The column counter wraps to 0 after cfg_width-1 and toggles row parity.
- Even row: hmax is written to line buffer entry col/2.
- Odd row:
  - pooled = max(hmax, line buffer entry col/2).
  - q = pooled >> cfg_shift, saturated to 255 if the shifted value exceeds 255.
  - q is written into the pack register at byte index byte_cnt, and byte_cnt increments.
- Word completion:
  - When byte_cnt reaches 4, the full word is pushed into the FIFO on the same edge and byte_cnt returns to 0.
  - Latency from the last contributing in_valid cycle N to out_valid is cycle N+1 when the FIFO was empty.
- flush with byte_cnt>0:
  - Pushes the pack register with the unfilled upper bytes set to 0, then clears byte_cnt.
  - flush with byte_cnt=0 has no effect.
  - flush coinciding with an in_valid that completes a byte: that byte is included before the push.
- FIFO:
  - out_valid = not empty. out_data = head entry, or 0 when empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when full: allowed, no drop.
  - Push when full without a pop: the word is dropped and ovf is set to 1. ovf holds until start or reset.
- A frame with an odd number of rows leaves its final row unused in the line buffer; no output is produced for it.

Test Plan:
- Basic pooling and packing:
  - Setup: cfg_width=4, cfg_shift=0, out_ready=1.
  - Stimulus rows: [1,5,3,2], [4,0,7,9], [10,20,30,40], [1,2,3,400].
  - Required response: a single out_valid pulse with out_data=0xFF140905, one cycle after the 16th pixel. This also checks saturation of 400 to 0xFF.
- Shift: same stimulus with cfg_shift=2 -> out_data=0x64050201 (400>>2=100).
- Flush partial word: cfg_width=2, rows [8,3], [6,12], then flush -> out_data=0x0000000C.
- Backpressure and overflow:
  - Setup: OUT_DEPTH=4, out_ready=0.
  - Stimulus: produce 5 words.
  - Required response: ovf=1 and 4 words retained. With out_ready=1 they drain in order and out_valid drops after the 4th.
- Full with simultaneous pop:
  - Setup: FIFO full.
  - Stimulus: push and pop in the same cycle.
  - Required response: ovf stays 0 and word count stays 4.
- Reset and restart:
  - Reset: assert rst_n=0 mid-row -> out_valid=0, out_data=0, ovf=0 immediately.
  - Restart: start with cfg_width=4 and rerun the basic pooling test -> identical 0xFF140905.

Source files
------------

// File: rtl/pool_quant_pack_if.sv
// Stream bundle for pool_quant_pack: frame control, pixel input and packed-word output.
// The master drives frame control and pixels; the slave returns the FIFO head and overflow flag.
interface pool_quant_pack_if #(
  parameter int DATA_WIDTH = 25,
  parameter int W_BITS     = 7
);
  logic                  start;
  logic [W_BITS-1:0]     cfg_width;
  logic [4:0]            cfg_shift;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic                  ovf;

  modport master (
    output start, cfg_width, cfg_shift, in_valid, in_data, flush, out_ready,
    input  out_valid, out_data, ovf
  );

  modport slave (
    input  start, cfg_width, cfg_shift, in_valid, in_data, flush, out_ready,
    output out_valid, out_data, ovf
  );
endinterface

// File: rtl/pool_quant_pack.sv
// 2x2 stride-2 max pooling on a raster pixel stream, requantization to 8 bits,
// packing of four activations per 32-bit word, and a small output FIFO.
module pool_quant_pack #(
  parameter int DATA_WIDTH = 25,
  parameter int MAX_W      = 64,
  parameter int W_BITS     = 7,
  parameter int OUT_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pool_quant_pack_if.slave  io_bus
);
  localparam int LB_DEPTH = MAX_W / 2;
  localparam int LB_AW    = $clog2(LB_DEPTH);
  localparam int PTR_W    = $clog2(OUT_DEPTH);

  logic [W_BITS-1:0]     r_width;
  logic [W_BITS-1:0]     r_col;
  logic [4:0]            r_shift;
  logic                  r_rowOdd;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [31:0]           r_pack;
  logic [1:0]            r_byteCnt;
  logic [PTR_W:0]        r_wrPtr;
  logic [PTR_W:0]        r_rdPtr;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_lineBuf [LB_DEPTH];
  logic [31:0]           r_fifoMem [OUT_DEPTH];

  logic                  w_accept;
  logic [LB_AW-1:0]      w_lbIdx;
  logic [DATA_WIDTH-1:0] w_lbRd;
  logic [DATA_WIDTH-1:0] w_hmax;
  logic [DATA_WIDTH-1:0] w_pooled;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [7:0]            w_q;
  logic                  w_byteValid;
  logic [2:0]            w_cntAfter;
  logic [31:0]           w_packNext;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wrEn;
  logic                  w_drop;
  logic                  w_lastCol;

  assign w_accept    = io_bus.in_valid & ~io_bus.start;
  assign w_lbIdx     = r_col[LB_AW:1];
  assign w_lbRd      = r_lineBuf[w_lbIdx];
  assign w_hmax      = (io_bus.in_data > r_pair) ? io_bus.in_data : r_pair;
  assign w_pooled    = (w_lbRd > w_hmax) ? w_lbRd : w_hmax;
  assign w_shifted   = w_pooled >> r_shift;
  assign w_q         = (|w_shifted[DATA_WIDTH-1:8]) ? 8'hFF : w_shifted[7:0];
  assign w_byteValid = w_accept & r_col[0] & r_rowOdd;
  assign w_cntAfter  = {1'b0, r_byteCnt} + {2'b00, w_byteValid};
  assign w_lastCol   = (r_col == r_width - W_BITS'(1));

  // The pack register is zeroed after every push, so a flushed partial word already has zero upper bytes.
  always_comb begin
    w_packNext = r_pack;
    if (w_byteValid) begin
      w_packNext[{r_byteCnt, 3'b000} +: 8] = w_q;
    end
  end

  assign w_push  = ~io_bus.start &
                   ((w_cntAfter == 3'd4) | (io_bus.flush & (w_cntAfter != 3'd0)));
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]) &
                   (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]);
  assign w_pop   = ~w_empty & io_bus.out_ready;
  assign w_wrEn  = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign io_bus.out_valid = ~w_empty;
  assign io_bus.out_data  = w_empty ? 32'd0 : r_fifoMem[r_rdPtr[PTR_W-1:0]];
  assign io_bus.ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width   <= '0;
      r_shift   <= '0;
      r_col     <= '0;
      r_rowOdd  <= 1'b0;
      r_pair    <= '0;
      r_pack    <= '0;
      r_byteCnt <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_ovf     <= 1'b0;
    end else if (io_bus.start) begin
      r_width   <= io_bus.cfg_width;
      r_shift   <= io_bus.cfg_shift;
      r_col     <= '0;
      r_rowOdd  <= 1'b0;
      r_pair    <= '0;
      r_pack    <= '0;
      r_byteCnt <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!r_col[0]) begin
          r_pair <= io_bus.in_data;
        end
        if (w_lastCol) begin
          r_col    <= '0;
          r_rowOdd <= ~r_rowOdd;
        end else begin
          r_col <= r_col + W_BITS'(1);
        end
      end
      r_pack    <= w_push ? 32'd0 : w_packNext;
      r_byteCnt <= w_push ? 2'd0 : w_cntAfter[1:0];
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; the pointers and counters above decide what is live.
  always_ff @(posedge clk) begin
    if (w_accept && r_col[0] && !r_rowOdd) begin
      r_lineBuf[w_lbIdx] <= w_hmax;
    end
    if (w_wrEn) begin
      r_fifoMem[r_wrPtr[PTR_W-1:0]] <= w_packNext;
    end
  end
endmodule

// File: tb/tb_pool_quant_pack.sv
// Self-checking bench for pool_quant_pack: a frame-level pooling model with a word queue,
// compared against the DUT every cycle, plus hand-computed words for fixed frames.
module tb_pool_quant_pack;
  localparam int DATA_WIDTH = 25;
  localparam int MAX_W      = 64;
  localparam int W_BITS     = 7;
  localparam int OUT_DEPTH  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   cmpEn;

  pool_quant_pack_if #(.DATA_WIDTH(DATA_WIDTH), .W_BITS(W_BITS)) bus ();

  pool_quant_pack #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_W(MAX_W),
    .W_BITS(W_BITS),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: whole rows of pixels, a byte queue, and the expected FIFO contents.
  int          mW;
  int          mS;
  int          mCol;
  bit          mRowOdd;
  int unsigned mCur [MAX_W];
  int unsigned mPrev [MAX_W];
  byte unsigned mBytes [$];
  logic [31:0] mQ [$];
  bit          mOvf;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic byte unsigned quant(input int unsigned p, input int s);
    int unsigned v;
    v = p >> s;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic modelReset();
    mW = 0;
    mS = 0;
    mCol = 0;
    mRowOdd = 1'b0;
    mBytes.delete();
    mQ.delete();
    mOvf = 1'b0;
  endtask

  task automatic modelStep(input bit s, input bit v, input logic [DATA_WIDTH-1:0] d,
                           input bit f, input bit r);
    bit          doPop;
    bit          doPush;
    bit          wasFull;
    logic [31:0] word;
    int unsigned pooled;
    if (s) begin
      mW = int'(bus.cfg_width);
      mS = int'(bus.cfg_shift);
      mCol = 0;
      mRowOdd = 1'b0;
      mBytes.delete();
      mQ.delete();
      mOvf = 1'b0;
      return;
    end
    wasFull = (mQ.size() == OUT_DEPTH);
    doPop = (mQ.size() != 0) && r;
    doPush = 1'b0;
    word = '0;
    if (v) begin
      mCur[mCol] = int'(d);
      if (mRowOdd && (mCol % 2 == 1)) begin
        pooled = max2(max2(mPrev[mCol-1], mPrev[mCol]), max2(mCur[mCol-1], mCur[mCol]));
        mBytes.push_back(quant(pooled, mS));
      end
      mCol++;
      if (mCol == mW) begin
        mCol = 0;
        if (!mRowOdd) mPrev = mCur;
        mRowOdd = !mRowOdd;
      end
    end
    if (mBytes.size() == 4 || (f && mBytes.size() > 0)) begin
      for (int i = 0; i < mBytes.size(); i++) word[8*i +: 8] = mBytes[i];
      mBytes.delete();
      doPush = 1'b1;
    end
    if (doPop) void'(mQ.pop_front());
    if (doPush) begin
      if (!wasFull || doPop) mQ.push_back(word);
      else mOvf = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge consume them, and advance the model alongside.
  task automatic applyStimulus(input bit s, input bit v, input logic [DATA_WIDTH-1:0] d,
                               input bit f, input bit r);
    bus.start = s;
    bus.in_valid = v;
    bus.in_data = d;
    bus.flush = f;
    bus.out_ready = r;
    @(posedge clk);
    modelStep(s, v, d, f, r);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model_valid", {31'd0, bus.out_valid}, {31'd0, mQ.size() != 0});
      checkOutput("model_data", bus.out_data, (mQ.size() != 0) ? mQ[0] : 32'd0);
      checkOutput("model_ovf", {31'd0, bus.ovf}, {31'd0, mOvf});
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rndPix();
    if ($urandom_range(0, 3) == 0) return DATA_WIDTH'($urandom);
    return DATA_WIDTH'($urandom_range(0, 600));
  endfunction

  task automatic startFrame(input int w, input int s, input bit r);
    bus.cfg_width = W_BITS'(w);
    bus.cfg_shift = 5'(s);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, r);
  endtask

  task automatic sendRows(input int w, input int rows, input bit lastReady);
    bit last;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        last = (r == rows - 1) && (c == w - 1);
        applyStimulus(1'b0, 1'b1, rndPix(), 1'b0, last ? lastReady : 1'b0);
      end
    end
  endtask

  task automatic drainCount(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) n++;
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
  endtask

  task automatic runBasic(input int s, input logic [31:0] expWord);
    int pix [16] = '{1, 5, 3, 2, 4, 0, 7, 9, 10, 20, 30, 40, 1, 2, 3, 400};
    startFrame(4, s, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) checkOutput("basic_before_last", {31'd0, bus.out_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, DATA_WIDTH'(pix[i]), 1'b0, 1'b1);
    end
    checkOutput("basic_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("basic_data", bus.out_data, expWord);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("basic_pulse_end", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int w;
    int rows;
    bit fl;
    checks = 0;
    failures = 0;
    cmpEn = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cfg_width = '0;
    bus.cfg_shift = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();
    #8;
    checkOutput("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_data", bus.out_data, 32'd0);
    checkOutput("reset_ovf", {31'd0, bus.ovf}, 32'd0);
    #4;
    rst_n = 1'b1;
    cmpEn = 1'b1;

    runBasic(0, 32'hFF140905);
    runBasic(2, 32'h64050201);

    // Partial word emitted by flush: single pooled value 12.
    startFrame(2, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, DATA_WIDTH'(8), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, DATA_WIDTH'(3), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, DATA_WIDTH'(6), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, DATA_WIDTH'(12), 1'b0, 1'b0);
    checkOutput("flush_before", {31'd0, bus.out_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("flush_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("flush_data", bus.out_data, 32'h0000000C);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("flush_empty_noop", {31'd0, bus.out_valid}, 32'd0);

    // Five words into a four-deep FIFO with no reader.
    startFrame(8, 0, 1'b0);
    sendRows(8, 10, 1'b0);
    checkOutput("ovf_set", {31'd0, bus.ovf}, 32'd1);
    drainCount(n);
    checkOutput("ovf_drain_count", 32'(n), 32'd4);
    checkOutput("ovf_drained_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("ovf_sticky", {31'd0, bus.ovf}, 32'd1);

    // Full FIFO taking a push and a pop on the same edge.
    startFrame(8, 1, 1'b0);
    checkOutput("start_clears_ovf", {31'd0, bus.ovf}, 32'd0);
    sendRows(8, 8, 1'b0);
    sendRows(8, 2, 1'b1);
    checkOutput("fullpop_ovf", {31'd0, bus.ovf}, 32'd0);
    drainCount(n);
    checkOutput("fullpop_count", 32'(n), 32'd4);

    // Asynchronous reset in the middle of a row with a full FIFO and ovf set.
    startFrame(8, 0, 1'b0);
    sendRows(8, 10, 1'b0);
    checkOutput("pre_reset_ovf", {31'd0, bus.ovf}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, rndPix(), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    cmpEn = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midreset_data", bus.out_data, 32'd0);
    checkOutput("midreset_ovf", {31'd0, bus.ovf}, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmpEn = 1'b1;
    runBasic(0, 32'hFF140905);

    // Randomized frames: widths, shifts, gaps, backpressure, odd row counts, stray flushes.
    for (int fr = 0; fr < 25; fr++) begin
      w = 2 * $urandom_range(1, 8);
      rows = $urandom_range(1, 5);
      bus.cfg_width = W_BITS'(w);
      bus.cfg_shift = 5'($urandom_range(0, 10));
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), rndPix(), 1'b0, 1'($urandom_range(0, 1)));
      for (int p = 0; p < w * rows; p++) begin
        if ($urandom_range(0, 2) == 0)
          applyStimulus(1'b0, 1'b0, rndPix(), 1'b0, 1'($urandom_range(0, 1)));
        fl = ($urandom_range(0, 15) == 0) || ((p == w * rows - 1) && ($urandom_range(0, 1) == 1));
        applyStimulus(1'b0, 1'b1, rndPix(), fl, 1'($urandom_range(0, 1)));
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
